md_sequencer: RTL and testbench



---
 rtl/md_sequencer.sv | 170 +++++++++++++++++
 tb/tb_md_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle HI/LO multiply/divide sequencer.
// Runs one bit per cycle: shift-add multiply and restoring divide, ITER iterations.
// The done pulse appears 34 edges after the edge that sampled start.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_cancel   request a new operation / abort the in-flight one
//   i_op                00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   i_src_a, i_src_b    multiplicand/dividend, multiplier/divisor
//   o_busy, o_stall     state != IDLE / combinational pipeline hold
//   o_done              one-cycle pulse, o_hi/o_lo valid
//   o_hi, o_lo          product high/low, or remainder/quotient
module md_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_cancel,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(ITER - 1);

    typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

    state_e r_state, w_state_next;

    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [WIDTH-1:0]   r_mag_a, r_mag_b;
    logic               r_neg_res, r_neg_rem;
    logic [CntW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_hi, r_lo;

    logic               w_idle_or_done, w_accept;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [2*WIDTH-1:0] w_addend, w_prod;
    logic [WIDTH:0]     w_rem_shift, w_trial;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix, w_hi, w_lo;

    assign w_idle_or_done = (r_state == StIdle) || (r_state == StDone);
    // cancel alongside start means the pipeline is flushing the requesting instruction
    assign w_accept = i_start && !i_cancel && w_idle_or_done;

    assign o_busy  = (r_state != StIdle);
    assign o_done  = (r_state == StDone);
    assign o_stall = (i_start && w_idle_or_done) ||
                     (r_state == StPrep) || (r_state == StCalc) || (r_state == StFix);
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;

    // abs(most negative) wraps to itself and is then read as an unsigned magnitude
    assign w_mag_a = (r_op[0] && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_mag_b = (r_op[0] && r_b[WIDTH-1]) ? -r_b : r_b;

    assign w_addend = {{WIDTH{1'b0}}, r_mag_a} << r_cnt;

    // r_quo starts as the dividend; its MSB feeds the remainder while quotient bits shift in.
    // The kept remainder is always below the divisor, so WIDTH bits of storage suffice and
    // only the trial subtract needs the extra bit.
    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial     = w_rem_shift - {1'b0, r_mag_b};

    assign w_prod    = r_neg_res ? -r_acc : r_acc;
    assign w_quo_fix = r_neg_res ? -r_quo : r_quo;
    assign w_rem_fix = r_neg_rem ? -r_rem : r_rem;

    always_comb begin
        w_hi = w_prod[2*WIDTH-1:WIDTH];
        w_lo = w_prod[WIDTH-1:0];
        if (r_op[1]) begin
            if (r_b == '0) begin
                // divide by zero: fixed result, sign fixup suppressed
                w_hi = r_a;
                w_lo = '1;
            end else begin
                w_hi = w_rem_fix;
                w_lo = w_quo_fix;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StPrep;
            StPrep:  w_state_next = i_cancel ? StIdle : StCalc;
            StCalc: begin
                if (i_cancel)              w_state_next = StIdle;
                else if (r_cnt == LastCnt) w_state_next = StFix;
            end
            StFix:   w_state_next = i_cancel ? StIdle : StDone;
            StDone:  w_state_next = w_accept ? StPrep : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (w_accept) begin
                r_op <= i_op;
                r_a  <= i_src_a;
                r_b  <= i_src_b;
            end
            unique case (r_state)
                StPrep: begin
                    r_mag_a   <= w_mag_a;
                    r_mag_b   <= w_mag_b;
                    r_neg_res <= r_op[0] && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_rem <= r_op[0] && r_a[WIDTH-1];
                    r_cnt     <= '0;
                    r_acc     <= '0;
                    r_rem     <= '0;
                    r_quo     <= w_mag_a;
                end
                StCalc: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!r_op[1]) begin
                        if (r_mag_b[r_cnt]) r_acc <= r_acc + w_addend;
                    end else if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                end
                StFix: begin
                    if (!i_cancel) begin
                        r_hi <= w_hi;
                        r_lo <= w_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: self-checking bench for md_sequencer.
// Directed vector table, hand-written multi-cycle sequences (back-to-back, cancel, reset,
// start while busy) and randomized operations checked against an arithmetic reference model.
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, cancel;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    md_sequencer #(.WIDTH(32), .ITER(32)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_cancel (cancel),
        .i_op     (op),
        .i_src_a  (src_a),
        .i_src_b  (src_b),
        .o_busy   (busy),
        .o_stall  (stall),
        .o_done   (done),
        .o_hi     (hi),
        .o_lo     (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference: {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: p = 64'(a) * 64'(b);
            2'b01: p = sa * sb;
            2'b10: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // At a negedge: raise start for one cycle; returns at the negedge after the sampling edge.
    task automatic issue_now(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        #1 check("stall on start", stall, 1'b1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // k counts negedges after the start-sampling edge; done expected at k == 34.
    task automatic wait_done(input int k0, input string tag, output int lat);
        bit stall_ok;
        stall_ok = 1'b1;
        lat = -1;
        for (int k = k0; k < k0 + 60; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (!stall || !busy) stall_ok = 1'b0;
            @(negedge clk);
        end
        check({tag, " latency"}, lat, 34);
        check({tag, " stall/busy in flight"}, 32'(stall_ok), 1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag, output logic [31:0] rhi, output logic [31:0] rlo);
        int lat;
        @(negedge clk);
        issue_now(o, a, b);
        wait_done(0, tag, lat);
        rhi = hi;
        rlo = lo;
        check({tag, " stall low in DONE"}, stall, 1'b0);
        @(negedge clk);
        check({tag, " done one cycle"}, done, 1'b0);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [31:0] rhi, rlo, prev_hi, prev_lo;
        logic [63:0] exp;
        int          lat;
        bit          saw_done;

        vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b10, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
        vecs[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{2'b10, 32'd10,        32'd3,         32'd1,         32'd3};
        vecs[6] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[7] = '{2'b11, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};

        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset stall", stall, 1'b0);
        check("reset done", done, 1'b0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), rhi, rlo);
            check($sformatf("vec%0d hi", i), rhi, vecs[i].hi);
            check($sformatf("vec%0d lo", i), rlo, vecs[i].lo);
        end

        // Back-to-back: DIV issued in the MULT's DONE cycle.
        @(negedge clk);
        issue_now(2'b01, 32'hFFFF_FFFD, 32'd5);
        wait_done(0, "b2b mult", lat);
        check("b2b mult hi", hi, 32'hFFFF_FFFF);
        check("b2b mult lo", lo, 32'hFFFF_FFF1);
        issue_now(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, "b2b div", lat);
        check("b2b div hi", hi, 32'hFFFF_FFFF);
        check("b2b div lo", lo, 32'hFFFF_FFFD);
        prev_hi = 32'hFFFF_FFFF;
        prev_lo = 32'hFFFF_FFFD;

        // Cancel while CALC is at cnt == 10.
        @(negedge clk);
        issue_now(2'b10, 32'd10, 32'd3);
        repeat (11) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel busy", busy, 1'b0);
        check("cancel stall", stall, 1'b0);
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("cancel no done", 32'(saw_done), 0);
        check("cancel hi kept", hi, prev_hi);
        check("cancel lo kept", lo, prev_lo);
        run_op(2'b10, 32'd10, 32'd3, "after cancel", rhi, rlo);
        check("after cancel hi", rhi, 32'd1);
        check("after cancel lo", rlo, 32'd3);

        // start together with cancel in IDLE is not accepted.
        @(negedge clk);
        op = 2'b00; src_a = 32'd2; src_b = 32'd2; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("start+cancel ignored", busy, 1'b0);

        // start while busy is ignored.
        @(negedge clk);
        issue_now(2'b00, 32'd7, 32'd9);
        repeat (5) @(negedge clk);
        op = 2'b10; src_a = 32'd1; src_b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, "start while busy", lat);
        check("busy-start hi", hi, 32'd0);
        check("busy-start lo", lo, 32'd63);
        @(negedge clk);
        check("busy-start no second op", busy, 1'b0);

        // Reset mid-CALC.
        @(negedge clk);
        issue_now(2'b00, 32'd123, 32'd456);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", busy, 1'b0);
        check("midrst stall", stall, 1'b0);
        check("midrst hi", hi, 32'h0);
        check("midrst lo", lo, 32'h0);
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("midrst no done", 32'(saw_done), 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 16));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            exp = model(ro, ra, rb);
            run_op(ro, ra, rb, $sformatf("rnd%0d op%0d", i, ro), rhi, rlo);
            check($sformatf("rnd%0d hi a=%08h b=%08h", i, ra, rb), rhi, exp[63:32]);
            check($sformatf("rnd%0d lo a=%08h b=%08h", i, ra, rb), rlo, exp[31:0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
